// File: rtl/prbs16_pkg.sv
// Shared constants and types for the PRBS16 checker: seed word, Fibonacci tap positions, FSM states.
package prbs16_pkg;

   localparam logic [15:0] SEED  = 16'hBEEF;
   localparam int unsigned TAP_A = 15;
   localparam int unsigned TAP_B = 13;
   localparam int unsigned TAP_C = 12;
   localparam int unsigned TAP_D = 10;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

endpackage

// File: rtl/lfsr16_next.sv
// Combinational one-step advance of the 16-bit Fibonacci LFSR.
module lfsr16_next
   import prbs16_pkg::*;
(
   input  logic [15:0] x_i,
   output logic [15:0] nxt_o
);

   assign nxt_o = {x_i[14:0], x_i[TAP_A] ^ x_i[TAP_B] ^ x_i[TAP_C] ^ x_i[TAP_D]};

endmodule

// File: rtl/prbs16_checker.sv
// Self-synchronising PRBS16 checker: HUNT -> VERIFY -> LOCKED with flywheel prediction and a saturating error counter.
// Optional build macro PRBS16_CHK_BITERR_EN counts mismatching bits instead of mismatching words.
module prbs16_checker
   import prbs16_pkg::*;
#(
   parameter int unsigned LOCK_COUNT   = 4,
   parameter int unsigned UNLOCK_COUNT = 3,
   parameter int unsigned ERR_W        = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   input  logic             clear_err,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [15:0]      expected
);

   localparam int unsigned      SUM_W    = ((ERR_W > 5) ? ERR_W : 5) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX  = {{(SUM_W - ERR_W){1'b0}}, {ERR_W{1'b1}}};
   localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);
   localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_COUNT);

   state_e           state_q;
   logic [3:0]       good_q;
   logic [3:0]       bad_q;
   logic [15:0]      exp_q;
   logic             locked_q;
   logic             pulse_q;
   logic [ERR_W-1:0] cnt_q;

   logic [ERR_W-1:0] cnt_d;
   logic [3:0]       good_inc;
   logic [3:0]       bad_inc;
   logic [4:0]       incr;
   logic [SUM_W-1:0] sum;
   logic             match;
   logic [15:0]      nxt_in;
   logic [15:0]      nxt_exp;

`ifdef PRBS16_CHK_BITERR_EN
   function automatic logic [4:0] popcnt16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction
`endif

   // Reseed path follows the data; flywheel path follows our own prediction.
   lfsr16_next u_nxt_in  (.x_i(in_data), .nxt_o(nxt_in));
   lfsr16_next u_nxt_exp (.x_i(exp_q),   .nxt_o(nxt_exp));

   always_comb begin
      match    = (in_data == exp_q);
      good_inc = good_q + 4'd1;
      bad_inc  = bad_q + 4'd1;
`ifdef PRBS16_CHK_BITERR_EN
      incr     = popcnt16(in_data ^ exp_q);
`else
      incr     = 5'd1;
`endif
      sum      = SUM_W'(cnt_q) + SUM_W'(incr);
      cnt_d    = (sum > CNT_MAX) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HUNT;
         good_q   <= '0;
         bad_q    <= '0;
         exp_q    <= '0;
         locked_q <= 1'b0;
         pulse_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         pulse_q <= 1'b0;
         if (clear_err) begin
            cnt_q <= '0;
         end
         if (in_valid) begin
            case (state_q)
               HUNT: begin
                  if (in_data != 16'h0000) begin
                     exp_q   <= nxt_in;
                     good_q  <= '0;
                     state_q <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (match) begin
                     exp_q  <= nxt_in;
                     good_q <= good_inc;
                     if (good_inc == LOCK_N) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        bad_q    <= '0;
                     end
                  end else if (in_data != 16'h0000) begin
                     exp_q  <= nxt_in;
                     good_q <= '0;
                  end else begin
                     state_q <= HUNT;
                  end
               end
               LOCKED: begin
                  exp_q <= nxt_exp;
                  if (match) begin
                     bad_q <= '0;
                  end else begin
                     pulse_q <= 1'b1;
                     bad_q   <= bad_inc;
                     // A same-cycle clear wins over the increment.
                     if (!clear_err) begin
                        cnt_q <= cnt_d;
                     end
                     if (bad_inc == UNLOCK_N) begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                        good_q   <= '0;
                     end
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign locked    = locked_q;
   assign err_pulse = pulse_q;
   assign err_count = cnt_q;
   assign expected  = exp_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed table-driven bench for prbs16_checker, plus a narrow-counter instance for saturation.
module tb_prbs16_checker;
   import prbs16_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'h0000;
   logic        clear_err = 1'b0;

   logic        locked, err_pulse;
   logic [15:0] err_count, expected;
   logic        s_locked, s_pulse;
   logic [1:0]  s_count;
   logic [15:0] s_expected;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   prbs16_checker u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_err(clear_err),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
   );

   prbs16_checker #(.ERR_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_err(clear_err),
      .locked(s_locked), .err_pulse(s_pulse), .err_count(s_count), .expected(s_expected)
   );

   typedef struct packed {
      logic        r;
      logic        v;
      logic        c;
      logic [15:0] d;
      logic        lk;
      logic        p;
      logic [15:0] cnt;
      logic [1:0]  sat;
      logic [15:0] ex;
      logic        skx;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic r, input logic v, input logic c, input logic [15:0] d,
                               input logic lk, input logic p, input logic [15:0] cnt,
                               input logic [1:0] sat, input logic [15:0] ex, input logic skx);
      vec_t t;
      t = '{r: r, v: v, c: c, d: d, lk: lk, p: p, cnt: cnt, sat: sat, ex: ex, skx: skx};
      vq.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic c, input logic [15:0] d);
      rst = r; in_valid = v; clear_err = c; in_data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Lock on the reference sequence
      add(1,0,0,16'h0000, 0,0,0,0,16'h0000,0);
      add(0,1,0,SEED,     0,0,0,0,16'h7DDE,0);
      add(0,1,0,16'h7DDE, 0,0,0,0,16'hFBBD,0);
      add(0,1,0,16'hFBBD, 0,0,0,0,16'hF77B,0);
      add(0,1,0,16'hF77B, 0,0,0,0,16'hEEF6,0);
      add(0,1,0,16'hEEF6, 1,0,0,0,16'hDDED,0);
      add(0,0,0,16'hDDED, 1,0,0,0,16'hDDED,0);
      add(0,1,0,16'hDDED, 1,0,0,0,16'hBBDB,0);
      // Single error then flywheel acceptance
      add(0,1,0,16'h0001, 1,1,1,1,16'h77B7,0);
      add(0,1,0,16'h77B7, 1,0,1,1,16'hEF6F,0);
      add(0,0,0,16'h5555, 1,0,1,1,16'hEF6F,0);
      // Loss of lock; narrow counter saturates on the third
      add(0,1,0,16'h1234, 1,1,2,2,16'hDEDF,0);
      add(0,1,0,16'h1234, 1,1,3,3,16'hBDBF,0);
      add(0,1,0,16'h1234, 0,1,4,3,16'h7B7E,0);
      // Relock
      add(0,1,0,16'hBEEF, 0,0,4,3,16'h7DDE,0);
      add(0,1,0,16'h7DDE, 0,0,4,3,16'hFBBD,0);
      add(0,1,0,16'hFBBD, 0,0,4,3,16'hF77B,0);
      add(0,1,0,16'hF77B, 0,0,4,3,16'hEEF6,0);
      add(0,1,0,16'hEEF6, 1,0,4,3,16'hDDED,0);
      // Clear priority with err_count=5
      add(0,1,0,16'h0000, 1,1,5,3,16'hBBDB,0);
      add(0,1,0,16'hBBDB, 1,0,5,3,16'h77B7,0);
      add(0,1,1,16'h0000, 1,1,0,0,16'hEF6F,0);
      add(0,1,0,16'hEF6F, 1,0,0,0,16'hDEDF,0);
      // Reset while locked
      add(1,1,0,16'hDEDF, 0,0,0,0,16'h0000,0);
      add(0,0,0,16'h0000, 0,0,0,0,16'h0000,0);
      // Zeros ignored in HUNT, 1111 reseeds VERIFY
      add(0,1,0,16'h0000, 0,0,0,0,16'h0000,0);
      add(0,1,0,16'h0000, 0,0,0,0,16'h0000,0);
      add(0,1,0,16'hBEEF, 0,0,0,0,16'h7DDE,0);
      add(0,1,0,16'h1111, 0,0,0,0,16'h2223,0);
      add(0,1,0,16'h7DDE, 0,0,0,0,16'hFBBD,0);
      add(0,1,0,16'hFBBD, 0,0,0,0,16'hF77B,0);
      add(0,1,0,16'hF77B, 0,0,0,0,16'hEEF6,0);
      add(0,1,0,16'hEEF6, 0,0,0,0,16'hDDED,0);
      add(0,1,0,16'hDDED, 1,0,0,0,16'hBBDB,0);
      // Zero in VERIFY drops to HUNT; restart from FBBD needs 4 more matches
      add(1,0,0,16'h0000, 0,0,0,0,16'h0000,0);
      add(0,1,0,16'hBEEF, 0,0,0,0,16'h7DDE,0);
      add(0,1,0,16'h7DDE, 0,0,0,0,16'hFBBD,0);
      add(0,1,0,16'h0000, 0,0,0,0,16'h0000,1);
      add(0,1,0,16'hFBBD, 0,0,0,0,16'hF77B,0);
      add(0,1,0,16'hF77B, 0,0,0,0,16'hEEF6,0);
      add(0,1,0,16'hEEF6, 0,0,0,0,16'hDDED,0);
      add(0,1,0,16'hDDED, 0,0,0,0,16'hBBDB,0);
      add(0,1,0,16'hBBDB, 1,0,0,0,16'h77B7,0);

      @(posedge clk);
      #1;
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].r, vq[i].v, vq[i].c, vq[i].d);
         chk($sformatf("row%0d locked", i), 32'(locked), 32'(vq[i].lk));
         chk($sformatf("row%0d err_pulse", i), 32'(err_pulse), 32'(vq[i].p));
         chk($sformatf("row%0d err_count", i), 32'(err_count), 32'(vq[i].cnt));
         chk($sformatf("row%0d sat_count", i), 32'(s_count), 32'(vq[i].sat));
         chk($sformatf("row%0d sat_pulse", i), 32'(s_pulse), 32'(vq[i].p));
         chk($sformatf("row%0d sat_locked", i), 32'(s_locked), 32'(vq[i].lk));
         if (!vq[i].skx) begin
            chk($sformatf("row%0d expected", i), 32'(expected), 32'(vq[i].ex));
            chk($sformatf("row%0d sat_expected", i), 32'(s_expected), 32'(vq[i].ex));
         end
      end

      // Long idle gap while locked: state and prediction hold, no pulses
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 16'hFFFF);
         chk($sformatf("gap%0d locked", k), 32'(locked), 32'd1);
         chk($sformatf("gap%0d err_pulse", k), 32'(err_pulse), 32'd0);
         chk($sformatf("gap%0d expected", k), 32'(expected), 32'h77B7);
      end
      // Mismatch, then clear on an idle cycle
      drive(0, 1, 0, 16'h0001);
      chk("err2 err_pulse", 32'(err_pulse), 32'd1);
      chk("err2 err_count", 32'(err_count), 32'd1);
      chk("err2 expected", 32'(expected), 32'hEF6F);
      drive(0, 0, 1, 16'h0000);
      chk("idleclr err_count", 32'(err_count), 32'd0);
      chk("idleclr err_pulse", 32'(err_pulse), 32'd0);
      chk("idleclr locked", 32'(locked), 32'd1);
      drive(0, 1, 0, 16'hEF6F);
      chk("after err_count", 32'(err_count), 32'd0);
      chk("after expected", 32'(expected), 32'hDEDF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs16_checker.md
Name: prbs16_checker

Overview:
- Receive-side counterpart of the 16-bit Fibonacci LFSR generator used in the design.
- Consumes a stream of 16-bit words that are claimed to be consecutive LFSR states, self-synchronises to the stream, declares lock, and counts errors once locked.
- Used for link and self-test checking of the randomness source and of any channel that carries LFSR words.

Parameters:
- LOCK_COUNT, 4: consecutive correct predictions required in VERIFY before asserting lock; legal range 1..15.
- UNLOCK_COUNT, 3: consecutive mispredictions in LOCKED that drop lock; legal range 1..15.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: in_data is a sample this cycle.
- in_data  in  16: received LFSR word.
- clear_err  in  1: synchronous clear of err_count.
- locked  out  1: high while in the LOCKED state.
- err_pulse  out  1: one-cycle pulse per mismatching word seen while LOCKED.
- err_count  out  ERR_W: saturating error count.
- expected  out  16: word predicted for the next valid sample.

Behaviour:
- Next-state function:
  - nxt(x) = {x[14:0], x[15]^x[13]^x[12]^x[10]}.
  - Examples: nxt(16'hBEEF)=16'h7DDE; nxt(16'h7DDE)=16'hFBBD.
- States:
  - HUNT: no reference word held.
  - VERIFY: counting good predictions.
  - LOCKED: flywheel checking.
- Reset values: state=HUNT, locked=0, err_pulse=0, err_count=0, expected=16'h0000, good_cnt=0, bad_cnt=0.
- Timing: all outputs are registered. Responses appear on the cycle after the in_valid sample. Nothing changes on cycles with in_valid=0, and err_pulse is 0 on those cycles.
- HUNT, on in_valid:
  - in_data==0 (LFSR lock-up word): ignored, stay in HUNT.
  - Otherwise: expected<=nxt(in_data), good_cnt<=0, go to VERIFY.
- VERIFY, on in_valid:
  - in_data==expected: good_cnt+1, expected<=nxt(in_data).
  - If the incremented good_cnt equals LOCK_COUNT: go to LOCKED, locked<=1, bad_cnt<=0.
  - Mismatch with in_data!=0: reseed, i.e. expected<=nxt(in_data), good_cnt<=0, stay in VERIFY.
  - Mismatch with in_data==0: go to HUNT.
  - No errors are counted in VERIFY.
- LOCKED, on in_valid:
  - expected<=nxt(expected) always. This is the flywheel: no reseed from the data.
  - Match: bad_cnt<=0.
  - Mismatch: err_pulse<=1, err_count increments (saturating at all-ones), bad_cnt+1.
  - If the incremented bad_cnt equals UNLOCK_COUNT: go to HUNT, locked<=0, good_cnt<=0. The error is still counted on that word.
- clear_err:
  - Zeroes err_count on the next edge.
  - Takes priority over an increment in the same cycle; that increment is dropped, but err_pulse still fires.
- Saturation: at 2^ERR_W-1, err_count holds its value and err_pulse still fires.
- rst mid-stream: returns to the reset values on the next edge regardless of state. Lock is lost.

Optional Feature:
- Macro: PRBS16_CHK_BITERR_EN.
- Defined: a LOCKED mismatch increments err_count by popcount(in_data ^ expected), 1..16, saturating. err_pulse behaviour is unchanged.
- Undefined: the increment is 1 per mismatching word. No popcount logic is built.

Decomposition:
- Package prbs16_pkg holds:
  - SEED=16'hBEEF;
  - tap constants 15, 13, 12, 10;
  - an enum typedef for state {HUNT, VERIFY, LOCKED}.
- One natural sub-module: lfsr16_next, purely combinational nxt(x). Instantiated twice: once on in_data for reseeding, once on expected for the flywheel.
- The optional popcount is an in-module function.

Test Plan:
- Lock: rst, then drive BEEF, 7DDE, FBBD, and the next two sequence words, one per cycle -> locked rises 1 cycle after the 5th word (4 good predictions); err_count=0; expected=nxt of the last word.
- Single error: while locked, replace one word by 16'h0001 -> err_pulse 1 cycle, err_count=1, locked stays 1, and the following correct word is accepted thanks to the flywheel. With PRBS16_CHK_BITERR_EN, err_count=popcount(0001^expected).
- Loss of lock: while locked, drive 3 consecutive words of 16'h1234 -> err_count+3, locked falls after the 3rd; a fresh 5-word valid run relocks.
- Zero and reseed: drive 0000, 0000, then BEEF, 1111, 7DDE… -> stays in HUNT during the zeros; 1111 reseeds VERIFY, so lock needs 4 matches after 1111.
- Clear priority: with err_count=5, assert clear_err on the same cycle as a locked mismatch -> err_count=0, err_pulse=1.
- Gaps and reset: insert idle cycles (in_valid=0) in a locked stream -> no state change; assert rst while locked -> locked=0, err_count=0, expected=0 next cycle.
